// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
// Optional build macro: KEYPAD_REPEAT_EN (auto-repeat of key_valid while held).
package keypad_pkg;

    localparam int NUM_ROWS         = 4;
    localparam int NUM_COLS         = 4;
    localparam int TICK_DIV_DEFAULT = 50000;   // 1 ms at 50 MHz
    localparam int TICK_W           = 20;      // scan tick counter width
    localparam int DEB_W            = 8;       // press/release debounce counters
    localparam int REP_W            = 10;      // auto-repeat counter

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } state_e;

    // Index of the lowest active-low row; the lower index wins on ties.
    function automatic logic [1:0] first_low(input logic [NUM_ROWS-1:0] rows);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = NUM_ROWS - 1; i >= 0; i--) begin
            if (!rows[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_scan_tick.sv
// scan_tick_gen: free-running divider producing a one-cycle scan tick
// every TICK_DIV clocks (count 0..TICK_DIV-1, tick on the last count).
module scan_tick_gen
    import keypad_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_DEFAULT
) (
    input  logic clk_50M,
    input  logic reset,
    output logic tick
);

    localparam logic [TICK_W-1:0] TERM = TICK_W'(TICK_DIV - 1);

    logic [TICK_W-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == TERM);

    // Wrap to zero on the tick cycle, otherwise count up.
    always_comb begin
        cnt_d = tick ? '0 : cnt_q + 1'b1;
    end

    // Divider register.
    always_ff @(posedge clk_50M or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 matrix keypad scanner with press/release debounce.
// Columns are driven one-hot active-low; rows are read back through a
// 2-flop synchronizer. Accepted keys are reported as {row_idx, col_idx}
// with a one-cycle key_valid strobe and a key_held level.
// Optional build macro: KEYPAD_REPEAT_EN re-strobes key_valid every
// REPEAT_TICKS ticks while the accepted key stays down.
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int TICK_DIV       = TICK_DIV_DEFAULT,
    parameter int DEBOUNCE_TICKS = 10,
    parameter int REPEAT_TICKS   = 500
) (
    input  logic                clk_50M,
    input  logic                reset,
    input  logic [NUM_ROWS-1:0] key_row,
    output logic [NUM_COLS-1:0] key_col,
    output logic [3:0]          key_code,
    output logic                key_valid,
    output logic                key_held
);

    localparam logic [DEB_W-1:0] DEB_TERM = DEB_W'(DEBOUNCE_TICKS - 1);

    logic                tick;
    logic [NUM_ROWS-1:0] row_meta_q, rows_s_q;
    state_e              state_q, state_d;
    logic [1:0]          col_q, col_d;
    logic [1:0]          row_idx_q, row_idx_d;
    logic [DEB_W-1:0]    deb_cnt_q, deb_cnt_d;
    logic [DEB_W-1:0]    rel_cnt_q, rel_cnt_d;
    logic [3:0]          code_q, code_d;
    logic                valid_q, valid_d;
    logic                held_q, held_d;
    logic                cap_low;

`ifdef KEYPAD_REPEAT_EN
    localparam logic [REP_W-1:0] REP_TERM = REP_W'(REPEAT_TICKS - 1);
    logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
`else
    // The parameter set stays identical in both builds; nothing uses it here.
    logic unused_repeat_cfg;
    assign unused_repeat_cfg = ^REPEAT_TICKS;
`endif

    scan_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk_50M (clk_50M),
        .reset   (reset),
        .tick    (tick)
    );

    assign key_col   = ~(4'b0001 << col_q);
    assign key_code  = code_q;
    assign key_valid = valid_q;
    assign key_held  = held_q;

    // The captured row is read on the frozen column while debouncing/held.
    assign cap_low = ~rows_s_q[row_idx_q];

    // Two-flop synchronizer; idle keypad reads all-ones.
    always_ff @(posedge clk_50M or posedge reset) begin
        if (reset) begin
            row_meta_q <= '1;
            rows_s_q   <= '1;
        end else begin
            row_meta_q <= key_row;
            rows_s_q   <= row_meta_q;
        end
    end

    // Scan/debounce FSM: next state and outputs, evaluated only on ticks.
    // Counters cannot pass their terminal values because reaching the
    // terminal value always causes a state change.
    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        row_idx_d = row_idx_q;
        deb_cnt_d = deb_cnt_q;
        rel_cnt_d = rel_cnt_q;
        code_d    = code_q;
        valid_d   = 1'b0;
        held_d    = held_q;
`ifdef KEYPAD_REPEAT_EN
        rep_cnt_d = rep_cnt_q;
`endif
        if (tick) begin
            unique case (state_q)
                SCAN: begin
                    if (&rows_s_q) begin
                        col_d = col_q + 2'd1;
                    end else begin
                        row_idx_d = first_low(rows_s_q);
                        deb_cnt_d = '0;
                        state_d   = DEBOUNCE;
                    end
                end
                DEBOUNCE: begin
                    if (cap_low) begin
                        if (deb_cnt_q == DEB_TERM) begin
                            state_d   = HELD;
                            code_d    = {row_idx_q, col_q};
                            valid_d   = 1'b1;
                            held_d    = 1'b1;
                            rel_cnt_d = '0;
`ifdef KEYPAD_REPEAT_EN
                            rep_cnt_d = '0;
`endif
                        end else begin
                            deb_cnt_d = deb_cnt_q + 1'b1;
                        end
                    end else begin
                        state_d = SCAN;
                        col_d   = col_q + 2'd1;
                    end
                end
                HELD: begin
                    if (cap_low) begin
                        rel_cnt_d = '0;
`ifdef KEYPAD_REPEAT_EN
                        if (rep_cnt_q == REP_TERM) begin
                            valid_d   = 1'b1;
                            rep_cnt_d = '0;
                        end else begin
                            rep_cnt_d = rep_cnt_q + 1'b1;
                        end
`endif
                    end else begin
`ifdef KEYPAD_REPEAT_EN
                        rep_cnt_d = '0;
`endif
                        if (rel_cnt_q == DEB_TERM) begin
                            state_d   = SCAN;
                            held_d    = 1'b0;
                            col_d     = col_q + 2'd1;
                            rel_cnt_d = '0;
                        end else begin
                            rel_cnt_d = rel_cnt_q + 1'b1;
                        end
                    end
                end
                default: state_d = SCAN;
            endcase
        end
    end

    // FSM and output registers.
    always_ff @(posedge clk_50M or posedge reset) begin
        if (reset) begin
            state_q   <= SCAN;
            col_q     <= 2'd0;
            row_idx_q <= 2'd0;
            deb_cnt_q <= '0;
            rel_cnt_q <= '0;
            code_q    <= 4'h0;
            valid_q   <= 1'b0;
            held_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            row_idx_q <= row_idx_d;
            deb_cnt_q <= deb_cnt_d;
            rel_cnt_q <= rel_cnt_d;
            code_q    <= code_d;
            valid_q   <= valid_d;
            held_q    <= held_d;
        end
    end

`ifdef KEYPAD_REPEAT_EN
    // Auto-repeat counter.
    always_ff @(posedge clk_50M or posedge reset) begin
        if (reset) rep_cnt_q <= '0;
        else       rep_cnt_q <= rep_cnt_d;
    end
`endif

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan (TICK_DIV=4, DEBOUNCE_TICKS=3, REPEAT_TICKS=5).
// A small key-matrix model pulls a row low while its pressed key's column
// is driven low. Honours KEYPAD_REPEAT_EN for the repeat expectations.
module tb_keypad_scan;

    logic       clk_50M = 1'b0;
    logic       reset   = 1'b1;
    logic [3:0] key_row;
    logic [3:0] key_col;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    logic [3:0][3:0] pressed;   // pressed[row][col]
    int checks = 0;
    int fails  = 0;
    int vcnt   = 0;             // key_valid pulses seen so far
    int snap;

    keypad_scan #(.TICK_DIV(4), .DEBOUNCE_TICKS(3), .REPEAT_TICKS(5)) dut (
        .clk_50M   (clk_50M),
        .reset     (reset),
        .key_row   (key_row),
        .key_col   (key_col),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    always #10 clk_50M = ~clk_50M;

    // Passive key matrix.
    always_comb begin
        key_row = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r][c] && !key_col[c]) key_row[r] = 1'b0;
    end

    // Strobe counter.
    always @(posedge clk_50M) if (key_valid === 1'b1) vcnt++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (key_valid !== 1'b1 && n < 200) begin
            @(negedge clk_50M);
            n++;
        end
        chk(tag, {31'd0, key_valid}, 32'd1);
    endtask

    initial begin
        pressed = '0;
        // Reset state
        repeat (3) @(negedge clk_50M);
        chk("rst_col",   key_col,   4'b1110);
        chk("rst_code",  key_code,  4'h0);
        chk("rst_valid", key_valid, 1'b0);
        chk("rst_held",  key_held,  1'b0);
        reset = 1'b0;
        // Column rotation every 4 clocks
        repeat (4) @(negedge clk_50M); chk("rot1", key_col, 4'b1101);
        repeat (4) @(negedge clk_50M); chk("rot2", key_col, 4'b1011);
        repeat (4) @(negedge clk_50M); chk("rot3", key_col, 4'b0111);
        repeat (4) @(negedge clk_50M); chk("rot0", key_col, 4'b1110);

        // Clean press row2/col1
        snap = vcnt;
        pressed[2][1] = 1'b1;
        wait_valid("press_valid");
        chk("press_code", key_code, 4'h9);
        chk("press_held", key_held, 1'b1);
        @(negedge clk_50M);
        chk("press_width", key_valid, 1'b0);
        repeat (16) @(negedge clk_50M);
        chk("press_once", vcnt - snap, 1);
        pressed = '0;
        repeat (24) @(negedge clk_50M);
        chk("rel_held", key_held, 1'b0);
        chk("rel_code", key_code, 4'h9);
        begin
            logic [3:0] c0;
            c0 = key_col;
            repeat (4) @(negedge clk_50M);
            chk("rel_scan", key_col, {c0[2:0], c0[3]});
        end

        // Bounce on row0/col3: low for 2 ticks only
        begin
            int n = 0;
            while (key_col == 4'b0111 && n < 50) begin @(negedge clk_50M); n++; end
            while (key_col != 4'b0111 && n < 50) begin @(negedge clk_50M); n++; end
        end
        chk("bnc_sync", key_col, 4'b0111);
        snap = vcnt;
        pressed[0][3] = 1'b1;
        repeat (8) @(negedge clk_50M);
        chk("bnc_frozen", key_col, 4'b0111);
        pressed = '0;
        repeat (4) @(negedge clk_50M);
        chk("bnc_col", key_col, 4'b1110);
        chk("bnc_held", key_held, 1'b0);
        repeat (8) @(negedge clk_50M);
        chk("bnc_novalid", vcnt - snap, 0);

        // Rows 1 and 3 on col0; second key during HELD
        pressed[1][0] = 1'b1;
        pressed[3][0] = 1'b1;
        wait_valid("multi_valid");
        chk("multi_code", key_code, 4'h4);
        @(negedge clk_50M);
        snap = vcnt;
        pressed[2][2] = 1'b1;
        repeat (15) @(negedge clk_50M);
        chk("second_nostrobe", vcnt - snap, 0);
        chk("second_code", key_code, 4'h4);
        pressed = '0;
        repeat (24) @(negedge clk_50M);
        chk("multi_rel", key_held, 1'b0);

        // Reset while HELD
        pressed[2][1] = 1'b1;
        wait_valid("rh_valid");
        @(negedge clk_50M);
        chk("rh_held", key_held, 1'b1);
        reset = 1'b1;
        #1;
        chk("rh_col",   key_col,   4'b1110);
        chk("rh_code",  key_code,  4'h0);
        chk("rh_valid", key_valid, 1'b0);
        chk("rh_held0", key_held,  1'b0);
        repeat (2) @(negedge clk_50M);
        snap = vcnt;
        reset = 1'b0;
        repeat (4) @(negedge clk_50M);
        chk("rh_nostrobe", vcnt - snap, 0);
        wait_valid("rh_again");
        chk("rh_again_code", key_code, 4'h9);
        chk("rh_again_held", key_held, 1'b1);
        pressed = '0;
        repeat (30) @(negedge clk_50M);
        chk("rh_rel", key_held, 1'b0);

        // Auto-repeat on row3/col3
        pressed[3][3] = 1'b1;
        wait_valid("rep_valid");
        chk("rep_code", key_code, 4'hF);
        @(negedge clk_50M);
        snap = vcnt;
        repeat (87) @(negedge clk_50M);
`ifdef KEYPAD_REPEAT_EN
        chk("rep_count", vcnt - snap, 4);
`else
        chk("rep_count", vcnt - snap, 0);
`endif
        chk("rep_code_keep", key_code, 4'hF);
        pressed = '0;
        repeat (30) @(negedge clk_50M);
        chk("rep_rel", key_held, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule

// File: doc/keypad_scan.md
Name: keypad_scan

Overview:
- Scans a 4x4 matrix keypad and produces a debounced key code plus a one-cycle valid strobe.
- Drives the columns active-low one at a time and reads the rows back. This is the input-side counterpart of the board's multiplexed 7-seg driver.
- Sits between the keypad header pins and the user logic. Its key_code can feed the display driver's digit input directly.

Parameters:
- TICK_DIV, 50000, clk_50M cycles per scan tick (1 ms at 50 MHz); legal range 2..2^20.
- DEBOUNCE_TICKS, 10, consecutive stable tick samples required for both press and release; legal range 1..255.
- REPEAT_TICKS, 500, ticks between auto-repeat strobes; used only when KEYPAD_REPEAT_EN is defined.

Ports:
- clk_50M  in  1  board 50 MHz clock
- reset  in  1  reset, asynchronous, active-high
- key_row  in  4  keypad rows, active-low (external pull-ups), asynchronous to clk_50M
- key_col  out  4  column drive, one-hot active-low
- key_code  out  4  last accepted key, {row_idx[1:0], col_idx[1:0]}
- key_valid  out  1  one-cycle strobe: key_code is new or repeated
- key_held  out  1  high while the accepted key is considered pressed

Behaviour:
- Reset values: key_col=4'b1110, key_code=4'h0, key_valid=0, key_held=0, state=SCAN, all counters=0.
- Row inputs: pass through a 2-flop synchronizer. All decisions use the synchronized value rows_s.
- Tick generator:
  - Counter runs 0..TICK_DIV-1, then wraps.
  - tick is high for one cycle when the count equals TICK_DIV-1.
  - All FSM actions below occur only on tick cycles.
- SCAN state:
  - On tick, if rows_s==4'hF: advance the column 0->1->2->3->0 (key_col rotates its low bit).
  - On tick, if any rows_s bit is low:
    - Capture col_idx (current column) and row_idx (lowest-indexed low row; lower index wins on multiple rows).
    - Clear deb_cnt and go to DEBOUNCE. The column stays frozen.
- DEBOUNCE state:
  - On tick, if captured row is low:
    - If deb_cnt==DEBOUNCE_TICKS-1: go to HELD. Load key_code, key_valid=1 for exactly the next cycle, key_held=1.
    - Otherwise deb_cnt++.
  - On tick, if captured row is high: return to SCAN and advance to the next column. No strobe.
- HELD state:
  - On tick, if captured row is low: rel_cnt=0.
  - On tick, if captured row is high: rel_cnt++.
  - When rel_cnt reaches DEBOUNCE_TICKS: go to SCAN, key_held=0, advance the column. key_code keeps its value.
  - Other keys pressed while HELD are ignored.
- Latency: key_valid is asserted 1 clock after the tick on which the DEBOUNCE_TICKS-th consecutive low sample is taken (plus the 2-cycle synchronizer delay).
  - Worst-case press-to-valid: (4+DEBOUNCE_TICKS) ticks.
- key_valid is never high on two consecutive cycles.
- key_held rises in the same cycle as the first key_valid.
- Reset asserted mid-operation (any state) returns immediately to the reset values. No strobe is issued on reset release.
- Widths:
  - Tick counter: 20 bits.
  - deb_cnt and rel_cnt: 8 bits, saturating at their terminal values.

Optional Feature:
- Macro KEYPAD_REPEAT_EN.
- Defined:
  - In HELD, rep_cnt (10 bits) counts ticks while the captured row is low.
  - On reaching REPEAT_TICKS: re-pulse key_valid for one cycle with the unchanged key_code, then clear rep_cnt.
  - rep_cnt clears on entry to HELD and on any high sample.
- Undefined: exactly one key_valid per accepted press. The rep_cnt logic is absent.

Decomposition:
- Package keypad_pkg:
  - State encodings SCAN=2'd0, DEBOUNCE=2'd1, HELD=2'd2.
  - NUM_ROWS=4, NUM_COLS=4.
  - Default TICK_DIV constant.
- One sub-module: scan_tick_gen (parameter TICK_DIV; ports clk_50M, reset, tick).

Test Plan:
(bench uses TICK_DIV=4, DEBOUNCE_TICKS=3, REPEAT_TICKS=5)
- Reset: assert reset with rows=4'hF -> key_col=4'b1110, key_code=0, key_valid=0, key_held=0. Thereafter key_col rotates 1110->1101->1011->0111->1110 every 4 clocks.
- Clean press of row2/col1 (key_row[2] low whenever key_col[1]==0), held for 40 cycles -> one key_valid pulse, key_code=4'h9, key_held=1. After release for ≥3 ticks -> key_held=0 and scanning resumes.
- Bounce: row0/col3 low for 2 ticks then high -> no key_valid, key_held stays 0, key_col advances past column 3 to column 0.
- Simultaneous rows 1 and 3 low on col0 -> key_code=4'h4. A second key pressed during HELD produces no strobe.
- Reset asserted while HELD (key_held=1) -> all outputs return to reset values the same cycle. With the key still pressed after reset release, a fresh key_valid occurs after the debounce.
- KEYPAD_REPEAT_EN defined, row3/col3 held for 30 ticks -> first strobe with key_code=4'hF, then further strobes every 5 ticks. Macro undefined -> exactly one strobe.
